dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-ported data memory.
- Port 0 is the load/store stage; port 1 is the secondary requester (program loader/debug).
- Arbitrates round-robin, issues one access at a time to the memory interface, and waits for read-data valid.
- Returns data, a one-cycle acknowledge, and an error flag on read timeout.

---
 rtl/dmem_arbiter_if.sv | 55 +++++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//
// Handshake: a requester raises pN_req with pN_we/pN_addr/pN_wdata and holds
// them stable until the arbiter returns a one-cycle pN_ack. pN_err and
// pN_rdata are meaningful in the pN_ack cycle. In the cycle after the ack the
// requester either drops pN_req or presents a new request. On the memory side,
// mem_enable stays high until the access resolves. For reads, the memory
// answers with a single-cycle mem_data_out_v carrying mem_data_out.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              p0_req;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic              p0_ack;
   logic              p0_err;
   logic [DATA_W-1:0] p0_rdata;

   logic              p1_req;
   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_ack;
   logic              p1_err;
   logic [DATA_W-1:0] p1_rdata;

   logic              mem_enable;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_write_enable;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_data_out_v;
   logic [DATA_W-1:0] mem_data_out;

   // Arbiter side
   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      output p0_ack, p0_err, p0_rdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      output p1_ack, p1_err, p1_rdata,
      output mem_enable, mem_addr, mem_write_enable, mem_data_in,
      input  mem_data_out_v, mem_data_out
   );

   // Requester / memory-model side
   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      input  p0_ack, p0_err, p0_rdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      input  p1_ack, p1_err, p1_rdata,
      input  mem_enable, mem_addr, mem_write_enable, mem_data_in,
      output mem_data_out_v, mem_data_out
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and sequencer for a single-ported data memory.
// One access in flight at a time; reads wait for mem_data_out_v with a
// bounded timeout that completes with an error flag.
module dmem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus,
   output logic           busy,
   output logic [1:0]     dbg_state
);

   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      WAIT_RD = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;      // port granted most recently
   logic              gnt_q, gnt_d;        // port owning the current access
   logic              we_q, we_d;          // current access is a write
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              men_q, men_d;
   logic              mwe_q, mwe_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [DATA_W-1:0] mdin_q, mdin_d;
   logic [1:0]        ack_q, ack_d;
   logic [1:0]        err_q, err_d;
   logic [DATA_W-1:0] rdata_q [2];
   logic [DATA_W-1:0] rdata_d [2];
   logic              sel;

   // Next-state and next-output computation for the access sequencer.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      gnt_d      = gnt_q;
      we_d       = we_q;
      cnt_d      = cnt_q;
      men_d      = men_q;
      mwe_d      = mwe_q;
      maddr_d    = maddr_q;
      mdin_d     = mdin_q;
      ack_d      = ack_q;
      err_d      = err_q;
      rdata_d[0] = rdata_q[0];
      rdata_d[1] = rdata_q[1];
      // On a tie the port that did not win last time goes next.
      sel        = (bus.p0_req && bus.p1_req) ? ~last_q : bus.p1_req;

      case (state_q)
         IDLE: begin
            if (bus.p0_req || bus.p1_req) begin
               gnt_d   = sel;
               last_d  = sel;
               we_d    = sel ? bus.p1_we    : bus.p0_we;
               maddr_d = sel ? bus.p1_addr  : bus.p0_addr;
               mdin_d  = sel ? bus.p1_wdata : bus.p0_wdata;
               men_d   = 1'b1;
               mwe_d   = sel ? bus.p1_we    : bus.p0_we;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (we_q) begin
               men_d        = 1'b0;
               mwe_d        = 1'b0;
               ack_d[gnt_q] = 1'b1;
               err_d[gnt_q] = 1'b0;
               state_d      = DONE;
            end else if (bus.mem_data_out_v) begin
               // Zero-wait memory: data already present in the enable cycle.
               rdata_d[gnt_q] = bus.mem_data_out;
               men_d          = 1'b0;
               ack_d[gnt_q]   = 1'b1;
               err_d[gnt_q]   = 1'b0;
               state_d        = DONE;
            end else begin
               cnt_d   = '0;
               state_d = WAIT_RD;
            end
         end
         WAIT_RD: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bus.mem_data_out_v) begin
               // Valid beats the timeout when both land together.
               rdata_d[gnt_q] = bus.mem_data_out;
               men_d          = 1'b0;
               ack_d[gnt_q]   = 1'b1;
               err_d[gnt_q]   = 1'b0;
               state_d        = DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rdata_d[gnt_q] = '0;
               men_d          = 1'b0;
               ack_d[gnt_q]   = 1'b1;
               err_d[gnt_q]   = 1'b1;
               state_d        = DONE;
            end
         end
         DONE: begin
            ack_d[gnt_q] = 1'b0;
            err_d[gnt_q] = 1'b0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Register all state and outputs; synchronous reset abandons any access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         gnt_q      <= 1'b0;
         we_q       <= 1'b0;
         cnt_q      <= '0;
         men_q      <= 1'b0;
         mwe_q      <= 1'b0;
         maddr_q    <= '0;
         mdin_q     <= '0;
         ack_q      <= '0;
         err_q      <= '0;
         rdata_q[0] <= '0;
         rdata_q[1] <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         gnt_q      <= gnt_d;
         we_q       <= we_d;
         cnt_q      <= cnt_d;
         men_q      <= men_d;
         mwe_q      <= mwe_d;
         maddr_q    <= maddr_d;
         mdin_q     <= mdin_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rdata_q[0] <= rdata_d[0];
         rdata_q[1] <= rdata_d[1];
      end
   end

   assign bus.p0_ack           = ack_q[0];
   assign bus.p0_err           = err_q[0];
   assign bus.p0_rdata         = rdata_q[0];
   assign bus.p1_ack           = ack_q[1];
   assign bus.p1_err           = err_q[1];
   assign bus.p1_rdata         = rdata_q[1];
   assign bus.mem_enable       = men_q;
   assign bus.mem_write_enable = mwe_q;
   assign bus.mem_addr         = maddr_q;
   assign bus.mem_data_in      = mdin_q;
   assign busy                 = (state_q != IDLE);
   assign dbg_state            = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases for write/read latency,
// round-robin alternation, timeout, valid-at-timeout and mid-access reset,
// followed by a short random sequence. Completions are checked against an
// expected queue filled when each request is driven.
module tb_dmem_arbiter;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;
   // Entry layout: {port, is_read, err, rdata}
   localparam int EW = 3 + DATA_W;

   logic       clk = 1'b0;
   logic       rst;
   logic       busy;
   logic [1:0] dbg_state;

   dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // Clock and global watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q [$];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
      bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
      bus.mem_data_out_v = 1'b0; bus.mem_data_out = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_busy"},  busy, 0);
      check({pfx, "_men"},   bus.mem_enable, 0);
      check({pfx, "_mwe"},   bus.mem_write_enable, 0);
      check({pfx, "_maddr"}, bus.mem_addr, 0);
      check({pfx, "_mdin"},  bus.mem_data_in, 0);
      check({pfx, "_acks"},  {bus.p1_ack, bus.p0_ack}, 0);
      check({pfx, "_errs"},  {bus.p1_err, bus.p0_err}, 0);
      check({pfx, "_rd0"},   bus.p0_rdata, 0);
      check({pfx, "_rd1"},   bus.p1_rdata, 0);
   endtask

   // Scoreboard: every ack pops the oldest expected completion.
   initial begin
      logic [EW-1:0]     e;
      logic              err_o;
      logic [DATA_W-1:0] rd_o;
      forever begin
         @(posedge clk);
         #2;
         if (bus.p0_ack || bus.p1_ack) begin
            check("sb_ack_onehot", bus.p0_ack & bus.p1_ack, 0);
            if (exp_q.size() == 0) begin
               check("sb_unexpected_ack", {bus.p1_ack, bus.p0_ack}, 0);
            end else begin
               e     = exp_q.pop_front();
               err_o = bus.p1_ack ? bus.p1_err : bus.p0_err;
               rd_o  = bus.p1_ack ? bus.p1_rdata : bus.p0_rdata;
               check("sb_port", bus.p1_ack, e[EW-1]);
               check("sb_err", err_o, e[EW-3]);
               if (e[EW-2]) check("sb_rdata", rd_o, e[DATA_W-1:0]);
            end
         end
      end
   end

   // Drive one access on one port with the other port idle. lat is the number
   // of cycles after the enable cycle before valid (0 = valid in the enable
   // cycle); lat < 0 means the memory never answers.
   task automatic do_op(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdat,
                        input int lat);
      bit got;
      bit ack;
      bit tmo;
      int exp_lat;
      tmo     = !we && (lat < 0);
      exp_lat = we ? 2 : (tmo ? TIMEOUT + 2 : lat + 2);
      if (port) begin
         bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
      end else begin
         bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
      end
      exp_q.push_back({port, !we, tmo, tmo ? {DATA_W{1'b0}} : rdat});
      tick();
      check("op_men_on", bus.mem_enable, 1);
      check("op_mwe", bus.mem_write_enable, we);
      check("op_maddr", bus.mem_addr, addr);
      if (we) check("op_mdin", bus.mem_data_in, wdata);
      got = 1'b0;
      for (int c = 1; c <= 40 && !got; c++) begin
         if (c > 1) tick();
         bus.mem_data_out_v = !we && !tmo && (c == lat + 1);
         bus.mem_data_out   = bus.mem_data_out_v ? rdat : DATA_W'($urandom);
         ack = port ? bus.p1_ack : bus.p0_ack;
         if (ack) begin
            got = 1'b1;
            check("op_latency", c, exp_lat);
            check("op_men_off", bus.mem_enable, 0);
            bus.p0_req = 1'b0;
            bus.p1_req = 1'b0;
         end
      end
      if (!got) check("op_no_ack", 0, 1);
      bus.mem_data_out_v = 1'b0;
      tick();
      check("op_idle_busy", busy, 0);
   endtask

   initial begin
      do_reset();
      check_reset_values("rst0");

      // Port 0 write
      do_op(1'b0, 1'b1, 32'h10, 32'hCAFEBABE, '0, 0);
      // Port 1 read, valid three cycles after enable
      do_op(1'b1, 1'b0, 32'h20, 32'h0BAD_F00D, 32'h12345678, 3);
      // Port 0 read where valid lands exactly on the timeout cycle
      do_op(1'b0, 1'b0, 32'h30, 32'h0, 32'hA5A55A5A, TIMEOUT);
      check("p1_rdata_hold", bus.p1_rdata, 32'h12345678);
      // Port 0 read timeout: previous nonzero rdata must clear
      do_op(1'b0, 1'b0, 32'h34, 32'h0, 32'h0, -1);
      check("p1_rdata_hold2", bus.p1_rdata, 32'h12345678);

      // Reset during WAIT_RD, late valid afterwards
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h44; bus.p0_wdata = 32'hDEADBEEF;
      tick();
      tick();
      tick();
      check("mid_busy", busy, 1);
      check("mid_state", dbg_state, 2);
      rst = 1'b1;
      tick();
      check_reset_values("rst_mid");
      rst = 1'b0;
      bus.p0_req = 1'b0;
      bus.mem_data_out_v = 1'b1;
      bus.mem_data_out   = 32'h55AA55AA;
      tick();
      tick();
      bus.mem_data_out_v = 1'b0;
      check("late_v_acks", {bus.p1_ack, bus.p0_ack}, 0);
      check("late_v_busy", busy, 0);
      do_op(1'b1, 1'b1, 32'h48, 32'h13579BDF, '0, 0);

      // Both ports requesting continuously after reset: p0, p1, p0
      do_reset();
      bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'h100; bus.p0_wdata = 32'h1;
      bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 32'h200; bus.p1_wdata = 32'h2;
      exp_q.push_back({1'b0, 1'b0, 1'b0, {DATA_W{1'b0}}});
      exp_q.push_back({1'b1, 1'b0, 1'b0, {DATA_W{1'b0}}});
      exp_q.push_back({1'b0, 1'b0, 1'b0, {DATA_W{1'b0}}});
      for (int c = 1; c <= 8; c++) begin
         tick();
         check("rr_p0_ack", bus.p0_ack, (c == 2 || c == 8));
         check("rr_p1_ack", bus.p1_ack, (c == 5));
         if (c == 1 || c == 7) check("rr_addr_p0", bus.mem_addr, 32'h100);
         if (c == 4) check("rr_addr_p1", bus.mem_addr, 32'h200);
      end
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
      tick();
      check("rr_idle", busy, 0);

      // Short random sequence
      for (int i = 0; i < 10; i++) begin
         logic [DATA_W-1:0] rv;
         rv = DATA_W'($urandom);
         do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ADDR_W'($urandom), DATA_W'($urandom), rv, int'($urandom_range(0, 5)));
      end

      tick();
      check("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
